poly_tone_voicer: RTL and testbench

//  Polyphonic successor to the single-key frequency decoder. Scans a key vector one key per clock
//  and assigns each newly pressed key to a free voice (up to NVOICE at once). Each voice runs a

---
 rtl/poly_tone_voicer.sv | 225 ++++++++++++++++++++++
 tb/tb_poly_tone_voicer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_tone_voicer.sv
// -----------------------------------------------------------------------------
// poly_tone_voicer
//   Polyphonic tone voicer. Scans the debounced key vector one key per clock,
//   binds each newly pressed key to the lowest-numbered free voice and frees
//   the voice when its key is released. Each active voice runs a half-period
//   counter and produces a square wave at the key's pitch. Key k is the
//   semitone k above C3.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   key           key held vector (1 = held), synchronous to clk
//   tone          per-voice square wave, 0 when the voice is idle
//   voice_active  per-voice allocation flag
//   voice_key     key index of voice v at [6v+5:6v], 0 when idle
//   voice_freq    nominal pitch in Hz of voice v at [32v+31:32v], 0 when idle
//   mix           number of voices whose tone is currently high
//   drop          one-cycle pulse: new key seen while every voice is busy
// -----------------------------------------------------------------------------
module poly_tone_voicer #(
   parameter int unsigned NKEYS  = 48,
   parameter int unsigned NVOICE = 4,
   parameter int unsigned CLK_HZ = 50000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NKEYS-1:0]         key,
   output logic [NVOICE-1:0]        tone,
   output logic [NVOICE-1:0]        voice_active,
   output logic [6*NVOICE-1:0]      voice_key,
   output logic [32*NVOICE-1:0]     voice_freq,
   output logic [3:0]               mix,
   output logic                     drop
);

   // Longest half period belongs to the lowest pitch (130 Hz).
   localparam int unsigned HMAX = CLK_HZ / 260;
   localparam int unsigned CW   = (HMAX < 2) ? 1 : $clog2(HMAX + 1);

   function automatic logic [31:0] freq_hz(input int unsigned k);
      case (k)
         0:  freq_hz = 32'd130;   1:  freq_hz = 32'd138;   2:  freq_hz = 32'd146;
         3:  freq_hz = 32'd155;   4:  freq_hz = 32'd164;   5:  freq_hz = 32'd174;
         6:  freq_hz = 32'd184;   7:  freq_hz = 32'd195;   8:  freq_hz = 32'd207;
         9:  freq_hz = 32'd220;   10: freq_hz = 32'd233;   11: freq_hz = 32'd246;
         12: freq_hz = 32'd261;   13: freq_hz = 32'd277;   14: freq_hz = 32'd293;
         15: freq_hz = 32'd311;   16: freq_hz = 32'd329;   17: freq_hz = 32'd349;
         18: freq_hz = 32'd369;   19: freq_hz = 32'd391;   20: freq_hz = 32'd415;
         21: freq_hz = 32'd440;   22: freq_hz = 32'd466;   23: freq_hz = 32'd493;
         24: freq_hz = 32'd523;   25: freq_hz = 32'd554;   26: freq_hz = 32'd587;
         27: freq_hz = 32'd622;   28: freq_hz = 32'd659;   29: freq_hz = 32'd698;
         30: freq_hz = 32'd739;   31: freq_hz = 32'd783;   32: freq_hz = 32'd830;
         33: freq_hz = 32'd880;   34: freq_hz = 32'd932;   35: freq_hz = 32'd987;
         36: freq_hz = 32'd1046;  37: freq_hz = 32'd1108;  38: freq_hz = 32'd1174;
         39: freq_hz = 32'd1244;  40: freq_hz = 32'd1318;  41: freq_hz = 32'd1396;
         42: freq_hz = 32'd1479;  43: freq_hz = 32'd1567;  44: freq_hz = 32'd1661;
         45: freq_hz = 32'd1760;  46: freq_hz = 32'd1864;  47: freq_hz = 32'd1975;
         default: freq_hz = 32'd0;
      endcase
   endfunction

   function automatic logic [NKEYS*32-1:0] build_freq_tab();
      logic [NKEYS*32-1:0] t;
      t = '0;
      for (int unsigned k = 0; k < NKEYS; k++) begin
         t[32*k +: 32] = freq_hz(k);
      end
      return t;
   endfunction

   // Stores HALF-1 so the counter wrap is a plain equality compare.
   // HALF is clamped to 1 so a very slow clock still yields a valid count.
   function automatic logic [NKEYS*32-1:0] build_hm1_tab();
      logic [NKEYS*32-1:0] t;
      logic [31:0]         h;
      t = '0;
      for (int unsigned k = 0; k < NKEYS; k++) begin
         h = CLK_HZ / (2 * freq_hz(k));
         if (h == '0) begin
            h = 32'd1;
         end
         t[32*k +: 32] = h - 32'd1;
      end
      return t;
   endfunction

   localparam logic [NKEYS*32-1:0] FREQ_TAB = build_freq_tab();
   localparam logic [NKEYS*32-1:0] HM1_TAB  = build_hm1_tab();

   logic [5:0]        scan_idx_q, scan_idx_d;
   logic [NVOICE-1:0] active_q,   active_d;
   logic [NVOICE-1:0] tone_q,     tone_d;
   logic [5:0]        vkey_q  [NVOICE];
   logic [5:0]        vkey_d  [NVOICE];
   logic [31:0]       vfreq_q [NVOICE];
   logic [31:0]       vfreq_d [NVOICE];
   logic [CW-1:0]     cnt_q   [NVOICE];
   logic [CW-1:0]     cnt_d   [NVOICE];
   logic [CW-1:0]     hm1_q   [NVOICE];
   logic [CW-1:0]     hm1_d   [NVOICE];
   logic [3:0]        mix_q,      mix_d;
   logic              drop_q,     drop_d;

   logic              key_bit;
   logic [31:0]       freq_sel;
   logic [CW-1:0]     hm1_sel;
   logic [NVOICE-1:0] hit_oh;
   logic [NVOICE-1:0] alloc_oh;
   logic [NVOICE-1:0] rel_oh;
   logic              free_found;

   always_comb begin
      // Key bit and ROM entries for the key under the scan pointer.
      key_bit  = 1'b0;
      freq_sel = '0;
      hm1_sel  = '0;
      for (int unsigned k = 0; k < NKEYS; k++) begin
         if (scan_idx_q == 6'(k)) begin
            key_bit  = key[k];
            freq_sel = FREQ_TAB[32*k +: 32];
            hm1_sel  = HM1_TAB[32*k +: CW];
         end
      end

      hit_oh     = '0;
      alloc_oh   = '0;
      rel_oh     = '0;
      free_found = 1'b0;
      drop_d     = 1'b0;
      for (int unsigned v = 0; v < NVOICE; v++) begin
         hit_oh[v] = active_q[v] && (vkey_q[v] == scan_idx_q);
      end

      // At most one allocation or one release per cycle.
      if (key_bit && (hit_oh == '0)) begin
         for (int unsigned v = 0; v < NVOICE; v++) begin
            if (!active_q[v] && !free_found) begin
               free_found  = 1'b1;
               alloc_oh[v] = 1'b1;
            end
         end
         drop_d = !free_found;
      end else if (!key_bit) begin
         rel_oh = hit_oh;
      end

      scan_idx_d = (scan_idx_q == 6'(NKEYS - 1)) ? '0 : scan_idx_q + 6'd1;

      active_d = active_q;
      tone_d   = tone_q;
      vkey_d   = vkey_q;
      vfreq_d  = vfreq_q;
      cnt_d    = cnt_q;
      hm1_d    = hm1_q;
      for (int unsigned v = 0; v < NVOICE; v++) begin
         if (alloc_oh[v]) begin
            active_d[v] = 1'b1;
            tone_d[v]   = 1'b0;
            vkey_d[v]   = scan_idx_q;
            vfreq_d[v]  = freq_sel;
            cnt_d[v]    = '0;
            hm1_d[v]    = hm1_sel;
         end else if (rel_oh[v]) begin
            active_d[v] = 1'b0;
            tone_d[v]   = 1'b0;
            vkey_d[v]   = '0;
            vfreq_d[v]  = '0;
            cnt_d[v]    = '0;
            hm1_d[v]    = '0;
         end else if (active_q[v]) begin
            if (cnt_q[v] == hm1_q[v]) begin
               cnt_d[v]  = '0;
               tone_d[v] = ~tone_q[v];
            end else begin
               cnt_d[v]  = cnt_q[v] + CW'(1);
            end
         end
      end

      // Counted from next-state values so mix lines up with tone.
      mix_d = '0;
      for (int unsigned v = 0; v < NVOICE; v++) begin
         mix_d = mix_d + {3'b000, tone_d[v] & active_d[v]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_idx_q <= '0;
         active_q   <= '0;
         tone_q     <= '0;
         vkey_q     <= '{default: '0};
         vfreq_q    <= '{default: '0};
         cnt_q      <= '{default: '0};
         hm1_q      <= '{default: '0};
         mix_q      <= '0;
         drop_q     <= 1'b0;
      end else begin
         scan_idx_q <= scan_idx_d;
         active_q   <= active_d;
         tone_q     <= tone_d;
         vkey_q     <= vkey_d;
         vfreq_q    <= vfreq_d;
         cnt_q      <= cnt_d;
         hm1_q      <= hm1_d;
         mix_q      <= mix_d;
         drop_q     <= drop_d;
      end
   end

   always_comb begin
      voice_key  = '0;
      voice_freq = '0;
      for (int unsigned v = 0; v < NVOICE; v++) begin
         voice_key[6*v +: 6]   = vkey_q[v];
         voice_freq[32*v +: 32] = vfreq_q[v];
      end
   end

   assign tone         = tone_q;
   assign voice_active = active_q;
   assign mix          = mix_q;
   assign drop         = drop_q;

endmodule

// File: tb/tb_poly_tone_voicer.sv
// -----------------------------------------------------------------------------
// tb_poly_tone_voicer
//   Directed and randomized checks of poly_tone_voicer against a reference
//   model that derives pitch from 440*2^((k-21)/12) and tone level from the
//   time elapsed since allocation.
// -----------------------------------------------------------------------------
module tb_poly_tone_voicer;

   localparam int NK    = 48;
   localparam int NV    = 4;
   localparam int CLKHZ = 26400;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [NK-1:0]   key = '0;
   logic [NV-1:0]   tone;
   logic [NV-1:0]   voice_active;
   logic [6*NV-1:0] voice_key;
   logic [32*NV-1:0] voice_freq;
   logic [3:0]      mix;
   logic            drop;

   always #5 clk = ~clk;

   poly_tone_voicer #(
      .NKEYS (NK),
      .NVOICE(NV),
      .CLK_HZ(CLKHZ)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key         (key),
      .tone        (tone),
      .voice_active(voice_active),
      .voice_key   (voice_key),
      .voice_freq  (voice_freq),
      .mix         (mix),
      .drop        (drop)
   );

   int total = 0;
   int bad   = 0;

   // Reference pitch tables from the equal-temperament formula.
   int rfreq [NK];
   int rhalf [NK];

   // Reference model state: edges since reset, scan pointer, voice bindings.
   int m_scan;
   int cyc;
   bit m_drop;
   bit m_act [NV];
   int m_key [NV];
   int m_t0  [NV];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_scan = 0;
      cyc    = 0;
      m_drop = 0;
      for (int v = 0; v < NV; v++) begin
         m_act[v] = 0;
         m_key[v] = 0;
         m_t0[v]  = 0;
      end
   endtask

   // Applies one rising edge to the model with the current key vector.
   task automatic model_edge();
      int holder;
      int freev;
      cyc++;
      m_drop = 0;
      holder = -1;
      freev  = -1;
      for (int v = 0; v < NV; v++) begin
         if (m_act[v] && m_key[v] == m_scan) holder = v;
      end
      for (int v = NV - 1; v >= 0; v--) begin
         if (!m_act[v]) freev = v;
      end
      if (key[m_scan] && holder < 0) begin
         if (freev >= 0) begin
            m_act[freev] = 1;
            m_key[freev] = m_scan;
            m_t0[freev]  = cyc;
         end else begin
            m_drop = 1;
         end
      end else if (!key[m_scan] && holder >= 0) begin
         m_act[holder] = 0;
      end
      m_scan = (m_scan + 1) % NK;
   endtask

   task automatic check_all();
      logic [NV-1:0]    ea, et;
      logic [6*NV-1:0]  ek;
      logic [32*NV-1:0] ef;
      logic [3:0]       em;
      ea = '0; et = '0; ek = '0; ef = '0; em = '0;
      for (int v = 0; v < NV; v++) begin
         if (m_act[v]) begin
            ea[v] = 1'b1;
            ek[6*v +: 6] = 6'(m_key[v]);
            ef[32*v +: 32] = 32'(rfreq[m_key[v]]);
            et[v] = (((cyc - m_t0[v]) / rhalf[m_key[v]]) % 2) == 1;
            if (et[v]) em = em + 4'd1;
         end
      end
      check("voice_active", 128'(voice_active), 128'(ea));
      check("voice_key",    128'(voice_key),    128'(ek));
      check("voice_freq",   128'(voice_freq),   128'(ef));
      check("tone",         128'(tone),         128'(et));
      check("mix",          128'(mix),          128'(em));
      check("drop",         128'(drop),         128'(m_drop));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_scan(input int n);
      int guard = 0;
      while (m_scan != n && guard < NK) begin
         tick();
         guard++;
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_tone"},   128'(tone),         128'(0));
      check({tag, "_active"}, 128'(voice_active), 128'(0));
      check({tag, "_key"},    128'(voice_key),    128'(0));
      check({tag, "_freq"},   128'(voice_freq),   128'(0));
      check({tag, "_mix"},    128'(mix),          128'(0));
      check({tag, "_drop"},   128'(drop),         128'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int drops;
      int allocs;
      logic [NV-1:0] prev;

      for (int k = 0; k < NK; k++) begin
         rfreq[k] = int'($floor(440.0 * (2.0 ** ((real'(k) - 21.0) / 12.0)) + 1.0e-6));
         rhalf[k] = CLKHZ / (2 * rfreq[k]);
      end
      check("half21", 128'(rhalf[21]), 128'(30));

      // Power-on reset, asserted between clock edges.
      #1 rst = 1'b1;
      #1 check_zero_outputs("por");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_all();

      // Single key 21.
      key[21] = 1'b1;
      ticks(49);
      check("k21_active", 128'(voice_active), 128'(4'b0001));
      check("k21_key",    128'(voice_key[5:0]), 128'(21));
      check("k21_freq",   128'(voice_freq[31:0]), 128'(440));
      ticks(120);

      // Lowest and highest keys.
      key = '0;
      ticks(NK);
      wait_scan(0);
      key[0]  = 1'b1;
      key[47] = 1'b1;
      ticks(NK);
      check("lohi_active", 128'(voice_active), 128'(4'b0011));
      check("lohi_key",    128'(voice_key[11:0]), 128'({6'd47, 6'd0}));
      ticks(404);
      wait_scan(0);
      key[0] = 1'b0;
      ticks(NK);
      check("rel0_active", 128'(voice_active), 128'(4'b0010));
      check("rel0_key1",   128'(voice_key[11:6]), 128'(47));
      ticks(30);

      // Five keys held, four voices.
      key = '0;
      ticks(NK);
      wait_scan(0);
      key[3] = 1'b1; key[5] = 1'b1; key[7] = 1'b1; key[9] = 1'b1; key[11] = 1'b1;
      drops = 0;
      repeat (3 * NK) begin
         tick();
         if (drop) drops++;
      end
      check("full_drops", 128'(drops), 128'(3));
      check("full_keys",  128'(voice_key), 128'({6'd9, 6'd7, 6'd5, 6'd3}));
      key[5] = 1'b0;
      drops = 0;
      ticks(NK);
      check("rebind_key1", 128'(voice_key[11:6]), 128'(11));
      repeat (2 * NK) begin
         tick();
         if (drop) drops++;
      end
      check("rebind_drops", 128'(drops), 128'(0));

      // Long hold of one key.
      key = '0;
      ticks(NK);
      wait_scan(0);
      key[12] = 1'b1;
      allocs = 0;
      drops  = 0;
      prev   = voice_active;
      repeat (500) begin
         tick();
         allocs += $countones(voice_active & ~prev);
         prev = voice_active;
         if (drop) drops++;
      end
      check("hold_allocs", 128'(allocs), 128'(1));
      check("hold_drops",  128'(drops),  128'(0));

      // Reset mid-tone with three voices active, then scan restarts at 0.
      key = '0;
      ticks(NK);
      wait_scan(0);
      key[0] = 1'b1; key[21] = 1'b1; key[47] = 1'b1;
      ticks(100);
      check("pre_rst_active", 128'(voice_active), 128'(4'b0111));
      #2 rst = 1'b1;
      #1 check_zero_outputs("midrst");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_zero_outputs("held_rst");
      rst = 1'b0;
      tick();
      check("restart_active", 128'(voice_active), 128'(4'b0001));
      check("restart_key",    128'(voice_key[5:0]), 128'(0));
      ticks(60);

      // Random sparse key vectors, each held for a few passes.
      for (int blk = 0; blk < 250; blk++) begin
         for (int k = 0; k < NK; k++) begin
            key[k] = ($urandom_range(0, 9) == 0);
         end
         ticks($urandom_range(40, 160));
         if (bad > 100) break;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
